// File: rtl/apb_mem_slv_p_pkg.sv
// apb_slv_pkg: shared types and width helpers for the APB memory slave.
// Provides the FSM state enum, strobe/index width helpers and the wait-counter width.
package apb_slv_pkg;
  typedef enum logic {IDLE, ACCESS} state_e;
  localparam int WAIT_CNT_W = 4;
  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction
  function automatic int idx_lsb(input int data_w);
    return $clog2(data_w / 8);
  endfunction
endpackage

// File: rtl/apb_mem_slv_p_if.sv
// apb_mem_slv_p_if: APB3/APB4 bus bundle.
// master drives psel/penable/pwrite/paddr/pwdata/pstrb; slave drives prdata/pready/pslverr.
interface apb_mem_slv_p_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) ();
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic [DATA_W-1:0]     prdata;
  logic                  pready;
  logic                  pslverr;
  modport master (output psel, penable, pwrite, paddr, pwdata, pstrb,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata, pstrb,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/apb_mem_slv_p_strb_ram.sv
// apb_strb_ram: DEPTH x DATA_W flop array with async clear, per-byte write enable, combinational read.
// Ports: clk, rst (async clear), be_i (byte enables), waddr_i, wdata_i, raddr_i, rdata_o.
module apb_strb_ram
  import apb_slv_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int DATA_W = 32,
  parameter int AW     = 9
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [strb_w(DATA_W)-1:0]   be_i,
  input  logic [AW-1:0]               waddr_i,
  input  logic [DATA_W-1:0]           wdata_i,
  input  logic [AW-1:0]               raddr_i,
  output logic [DATA_W-1:0]           rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int b = 0; b < strb_w(DATA_W); b++)
        if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/apb_mem_slv_p.sv
// apb_mem_slv_p: parametrised APB memory slave with byte strobes, wait states and range error.
// Ports: pclk, preset (async, active-high), bus (apb_mem_slv_p_if.slave).
module apb_mem_slv_p
  import apb_slv_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 0
) (
  input  logic            pclk,
  input  logic            preset,
  apb_mem_slv_p_if.slave  bus
);
  localparam int SW = strb_w(DATA_W);
  localparam int IL = idx_lsb(DATA_W);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  state_e                state_q;
  logic [WAIT_CNT_W-1:0] cnt_q;
  logic [AW-1:0]         idx_q;
  logic                  write_q, err_q, pready_q, pslverr_q;
  logic [DATA_W-1:0]     wdata_q, prdata_q, ram_rdata, rd_val;
  logic [SW-1:0]         strb_q, be;
  logic [ADDR_W-1:0]     idx_full;
  logic [AW-1:0]         idx_d, raddr;
  logic                  err_d, err_c, setup, live, we;
  assign idx_full = bus.paddr >> IL;
  assign idx_d    = idx_full[AW-1:0];
  assign err_d    = {1'b0, idx_full} >= DEPTH_W;
  assign setup    = bus.psel && !bus.penable;
  assign live     = bus.psel && bus.penable;
  // IDLE reads the incoming index (zero-wait case), ACCESS reads the latched one
  assign raddr    = (state_q == IDLE) ? idx_d : idx_q;
  assign err_c    = (state_q == IDLE) ? err_d : err_q;
  assign rd_val   = err_c ? '0 : ram_rdata;
  // memory commits only in the completion cycle of a non-aborted, in-range write
  assign we       = (state_q == ACCESS) && live && pready_q && write_q && !err_q;
  assign be       = strb_q & {SW{we}};
  apb_strb_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW)) u_ram (
    .clk     (pclk),
    .rst     (preset),
    .be_i    (be),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .raddr_i (raddr),
    .rdata_o (ram_rdata)
  );
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          if (setup) begin
            idx_q   <= idx_d;
            write_q <= bus.pwrite;
            wdata_q <= bus.pwdata;
            strb_q  <= bus.pstrb;
            err_q   <= err_d;
            cnt_q   <= WAIT_CNT_W'(WAIT_STATES);
            state_q <= ACCESS;
            if (WAIT_STATES == 0) begin
              pready_q  <= 1'b1;
              pslverr_q <= err_d;
              if (!bus.pwrite) prdata_q <= rd_val;
            end
          end
        end
        ACCESS: begin
          if (!live || pready_q) begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == WAIT_CNT_W'(1)) begin
              pready_q  <= 1'b1;
              pslverr_q <= err_q;
              if (!write_q) prdata_q <= rd_val;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.prdata  = prdata_q;
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
endmodule

// File: tb/tb_apb_mem_slv_p.sv
// tb_apb_mem_slv_p: random and directed checks of two slaves (0 and 3 wait states) against a word-array model.
module tb_apb_mem_slv_p;
  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        psel, penable, pwrite, sel;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  int          checks = 0;
  int          errs = 0;
  logic [31:0] m [2][512];
  logic [31:0] pr [2];
  always #5 pclk = ~pclk;
  apb_mem_slv_p_if #(.ADDR_W(12), .DATA_W(32)) if0 ();
  apb_mem_slv_p_if #(.ADDR_W(12), .DATA_W(32)) if3 ();
  assign if0.psel = psel & ~sel;
  assign if3.psel = psel & sel;
  assign if0.penable = penable;
  assign if3.penable = penable;
  assign if0.pwrite = pwrite;
  assign if3.pwrite = pwrite;
  assign if0.paddr = paddr;
  assign if3.paddr = paddr;
  assign if0.pwdata = pwdata;
  assign if3.pwdata = pwdata;
  assign if0.pstrb = pstrb;
  assign if3.pstrb = pstrb;
  apb_mem_slv_p #(.ADDR_W(12), .DATA_W(32), .DEPTH(512), .WAIT_STATES(0)) dut0 (
    .pclk(pclk), .preset(preset), .bus(if0));
  apb_mem_slv_p #(.ADDR_W(12), .DATA_W(32), .DEPTH(512), .WAIT_STATES(3)) dut3 (
    .pclk(pclk), .preset(preset), .bus(if3));
  function automatic logic rdy();
    return sel ? if3.pready : if0.pready;
  endfunction
  function automatic logic slverr();
    return sel ? if3.pslverr : if0.pslverr;
  endfunction
  function automatic logic [31:0] prd();
    return sel ? if3.prdata : if0.prdata;
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_clear();
    for (int s = 0; s < 2; s++) begin
      pr[s] = '0;
      for (int i = 0; i < 512; i++) m[s][i] = '0;
    end
  endtask
  // called at posedge+1; leaves the bus idle at posedge+1 after completion
  task automatic xfer(input logic s, input logic w, input logic [11:0] a,
                      input logic [31:0] d, input logic [3:0] st);
    int n;
    int ix;
    logic e;
    ix = int'(a >> 2);
    e = ix >= 512;
    sel = s; psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = st;
    @(posedge pclk); #1;
    penable = 1'b1;
    paddr = 12'($urandom); pwdata = $urandom; pstrb = 4'($urandom);
    n = 1;
    while (!rdy() && n < 40) begin
      @(posedge pclk); #1;
      n++;
    end
    chk("latency", 64'(n), s ? 64'd4 : 64'd1);
    chk("pslverr", 64'(slverr()), 64'(e));
    if (!w) pr[s] = e ? 32'd0 : m[s][ix];
    chk("prdata", 64'(prd()), 64'(pr[s]));
    @(posedge pclk); #1;
    if (w && !e)
      for (int b = 0; b < 4; b++) if (st[b]) m[s][ix][8*b +: 8] = d[8*b +: 8];
    chk("pready_drop", 64'(rdy()), 64'd0);
    psel = 1'b0; penable = 1'b0;
  endtask
  initial begin
    logic s, w;
    logic [11:0] a;
    sel = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    model_clear();
    #12;
    chk("rst_rdata0", 64'(if0.prdata), 64'd0);
    chk("rst_ready0", 64'(if0.pready), 64'd0);
    chk("rst_err3", 64'(if3.pslverr), 64'd0);
    preset = 1'b0;
    @(posedge pclk); #1;
    xfer(0, 1, 12'h010, 32'hDEADBEEF, 4'hF);
    xfer(0, 0, 12'h010, 32'h0, 4'h0);
    chk("rd_deadbeef", 64'(if0.prdata), 64'hDEADBEEF);
    xfer(0, 1, 12'h020, 32'h11223344, 4'hF);
    xfer(0, 1, 12'h020, 32'hAABBCCDD, 4'b0101);
    xfer(0, 0, 12'h020, 32'h0, 4'h0);
    chk("rd_strb", 64'(if0.prdata), 64'h11BB33DD);
    xfer(0, 1, 12'h020, 32'hFFFFFFFF, 4'h0);
    xfer(0, 0, 12'h020, 32'h0, 4'h0);
    chk("rd_strb0", 64'(if0.prdata), 64'h11BB33DD);
    xfer(0, 1, 12'h800, 32'hCAFEF00D, 4'hF);
    xfer(0, 0, 12'h800, 32'h0, 4'h0);
    chk("rd_err_data", 64'(if0.prdata), 64'd0);
    xfer(0, 0, 12'h000, 32'h0, 4'h0);
    chk("rd_word0", 64'(if0.prdata), 64'd0);
    xfer(1, 1, 12'h004, 32'h0BADBEEF, 4'hF);
    xfer(1, 0, 12'h004, 32'h0, 4'h0);
    chk("ws3_rd", 64'(if3.prdata), 64'h0BADBEEF);
    sel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h030; pwdata = 32'h55; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    chk("abort3_wait", 64'(if3.pready), 64'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    chk("abort3_idle", 64'(if3.pready), 64'd0);
    xfer(1, 0, 12'h030, 32'h0, 4'h0);
    chk("abort3_rd", 64'(if3.prdata), 64'd0);
    sel = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h030; pwdata = 32'h55; pstrb = 4'hF;
    @(posedge pclk); #1;
    psel = 1'b0;
    @(posedge pclk); #1;
    chk("abort0_idle", 64'(if0.pready), 64'd0);
    xfer(0, 0, 12'h030, 32'h0, 4'h0);
    chk("abort0_rd", 64'(if0.prdata), 64'd0);
    xfer(0, 0, 12'h010, 32'h0, 4'h0);
    sel = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h040; pwdata = 32'h1234; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    #2 preset = 1'b1;
    #1;
    chk("arst_rdata", 64'(if0.prdata), 64'd0);
    chk("arst_ready", 64'(if0.pready), 64'd0);
    chk("arst_err", 64'(if0.pslverr), 64'd0);
    psel = 1'b0; penable = 1'b0;
    model_clear();
    @(posedge pclk); #1;
    preset = 1'b0;
    @(posedge pclk); #1;
    xfer(0, 0, 12'h040, 32'h0, 4'h0);
    chk("arst_rd40", 64'(if0.prdata), 64'd0);
    xfer(0, 0, 12'h010, 32'h0, 4'h0);
    chk("arst_rd10", 64'(if0.prdata), 64'd0);
    for (int i = 0; i < 300; i++) begin
      s = 1'($urandom);
      w = 1'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 63));
      xfer(s, w, a, $urandom, 4'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
